// File: rtl/tlc_phase_sequencer_pkg.sv
// Shared state and light encodings for the phase sequencer and its round-robin picker.
package tlc_phase_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_GREEN  = 2'd0,
      ST_YELLOW = 2'd1,
      ST_ALLRED = 2'd2,
      ST_WALK   = 2'd3
   } tlc_state_e;

   localparam logic [1:0] TLC_RED    = 2'b00;
   localparam logic [1:0] TLC_YELLOW = 2'b01;
   localparam logic [1:0] TLC_GREEN  = 2'b10;

   // Aspect shown by the active approach in a given state; every other approach is RED.
   function automatic logic [1:0] light_code(input tlc_state_e st);
      case (st)
         ST_GREEN:  light_code = TLC_GREEN;
         ST_YELLOW: light_code = TLC_YELLOW;
         default:   light_code = TLC_RED;
      endcase
   endfunction

endpackage

// File: rtl/tlc_next_phase.sv
// Combinational round-robin picker: first requesting approach after 'phase', else phase+1.
module tlc_next_phase
   import tlc_phase_sequencer_pkg::*;
#(
   parameter int unsigned N_PHASES = 4,
   parameter int unsigned PW       = $clog2(N_PHASES)
) (
   input  logic [N_PHASES-1:0] req,
   input  logic [PW-1:0]       phase,
   output logic [PW-1:0]       nxt,
   output logic                found
);

   logic [PW-1:0] idx;

   always_comb begin
      nxt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N_PHASES; k++) begin
         idx = PW'((32'(phase) + k) % N_PHASES);
         if (!found && req[idx]) begin
            found = 1'b1;
            nxt   = idx;
         end
      end
      if (!found) begin
         nxt = PW'((32'(phase) + 32'd1) % N_PHASES);
      end
   end

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Sensor-actuated N-approach traffic-light sequencer with gap-out and rest-in-green.
// Optional pedestrian walk interval is enabled by defining TLC_PED_EN.
module tlc_phase_sequencer
   import tlc_phase_sequencer_pkg::*;
#(
   parameter int unsigned N_PHASES     = 4,
   parameter int unsigned TW           = 8,
   parameter int unsigned T_GREEN_OFF  = 10,
   parameter int unsigned T_GREEN_PEAK = 20,
   parameter int unsigned T_MIN_GREEN  = 4,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_ALLRED     = 1,
   parameter int unsigned T_WALK       = 8,
   localparam int unsigned PW          = $clog2(N_PHASES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  peak,
   input  logic [N_PHASES-1:0]   sensor,
   output logic [2*N_PHASES-1:0] lights,
   output logic [TW-1:0]         timer,
   output logic [PW-1:0]         phase,
   output logic [1:0]            state
`ifdef TLC_PED_EN
   ,
   input  logic                  ped_req,
   output logic                  walk
`endif
);

   localparam int unsigned MAX_DUR = (1 << TW) - 1;

   if (N_PHASES < 2 || N_PHASES > 8 ||
       T_GREEN_OFF  < 1 || T_GREEN_OFF  > MAX_DUR ||
       T_GREEN_PEAK < 1 || T_GREEN_PEAK > MAX_DUR ||
       T_MIN_GREEN  < 1 || T_MIN_GREEN  > T_GREEN_OFF || T_MIN_GREEN > T_GREEN_PEAK ||
       T_YELLOW     < 1 || T_YELLOW     > MAX_DUR ||
       T_ALLRED     < 1 || T_ALLRED     > MAX_DUR ||
       T_WALK       < 1 || T_WALK       > MAX_DUR) begin : g_bad_cfg
      $error("tlc_phase_sequencer: illegal parameter set");
   end

   tlc_state_e            state_q, state_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [TW-1:0]         g_el_q, g_el_d;
   logic [N_PHASES-1:0]   req_q, req_d;
   logic [2*N_PHASES-1:0] lights_q, lights_d;
   logic                  peak_q, peak_d;

   logic [N_PHASES-1:0]   phase_mask, green_mask;
   logic [PW-1:0]         nxt;
   logic                  nxt_found;
   logic [TW:0]           g_next;
   logic                  other_req, leave, expire, gap_ok, phase_ok, state_ok;
   logic [TW-1:0]         green_time;

`ifdef TLC_PED_EN
   logic ped_q, ped_d;
`endif

   tlc_next_phase #(
      .N_PHASES (N_PHASES),
      .PW       (PW)
   ) u_next (
      .req   (req_q),
      .phase (phase_q),
      .nxt   (nxt),
      .found (nxt_found)
   );

   always_comb begin
      phase_mask = '0;
      green_mask = '0;
      for (int unsigned i = 0; i < N_PHASES; i++) begin
         phase_mask[i] = (phase_q == PW'(i));
         green_mask[i] = phase_mask[i] && (state_q == ST_GREEN);
      end
   end

   assign other_req  = |(req_q & ~phase_mask);
`ifdef TLC_PED_EN
   assign leave      = other_req | ped_q;
   assign state_ok   = 1'b1;
`else
   assign leave      = other_req;
   assign state_ok   = (state_q != ST_WALK);
`endif
   assign phase_ok   = (32'(phase_q) < N_PHASES);
   assign expire     = (timer_q == TW'(1));
   assign g_next     = {1'b0, g_el_q} + (TW+1)'(1);
   assign gap_ok     = (g_next >= (TW+1)'(T_MIN_GREEN)) && !sensor[phase_q];
   assign green_time = peak_q ? TW'(T_GREEN_PEAK) : TW'(T_GREEN_OFF);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      timer_d = timer_q;
      g_el_d  = g_el_q;
      peak_d  = peak_q;
      req_d   = req_q | (sensor & ~green_mask);
`ifdef TLC_PED_EN
      ped_d   = ped_q | ped_req;
`endif

      if (tick) begin
         case (state_q)
            ST_GREEN: begin
               g_el_d = g_el_q + TW'(1);
               if (leave && (expire || gap_ok)) begin
                  state_d = ST_YELLOW;
                  timer_d = TW'(T_YELLOW);
               end else if (expire) begin
                  timer_d = green_time;
                  g_el_d  = '0;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            ST_YELLOW: begin
               if (expire) begin
                  state_d = ST_ALLRED;
                  timer_d = TW'(T_ALLRED);
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            ST_ALLRED: begin
               if (expire) begin
`ifdef TLC_PED_EN
                  if (ped_q) begin
                     state_d = ST_WALK;
                     timer_d = TW'(T_WALK);
                     ped_d   = 1'b0;
                  end else
`endif
                  begin
                     state_d = ST_GREEN;
                     phase_d = nxt;
                     peak_d  = peak;
                     timer_d = peak ? TW'(T_GREEN_PEAK) : TW'(T_GREEN_OFF);
                     g_el_d  = '0;
                     if (nxt_found) begin
                        req_d[nxt] = 1'b0;
                     end
                  end
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
`ifdef TLC_PED_EN
            ST_WALK: begin
               if (expire) begin
                  state_d = ST_ALLRED;
                  timer_d = TW'(T_ALLRED);
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
`endif
            default: ;
         endcase
      end

      // Corrupted state or phase recovers to a clean all-red interval regardless of tick.
      if (!state_ok || !phase_ok) begin
         state_d = ST_ALLRED;
         timer_d = TW'(T_ALLRED);
         if (!phase_ok) begin
            phase_d = PW'(N_PHASES - 1);
         end
      end

      for (int unsigned i = 0; i < N_PHASES; i++) begin
         lights_d[2*i +: 2] = (phase_d == PW'(i)) ? light_code(state_d) : TLC_RED;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_ALLRED;
         phase_q  <= PW'(N_PHASES - 1);
         timer_q  <= TW'(T_ALLRED);
         g_el_q   <= '0;
         req_q    <= '0;
         lights_q <= '0;
         peak_q   <= 1'b0;
`ifdef TLC_PED_EN
         ped_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         timer_q  <= timer_d;
         g_el_q   <= g_el_d;
         req_q    <= req_d;
         lights_q <= lights_d;
         peak_q   <= peak_d;
`ifdef TLC_PED_EN
         ped_q    <= ped_d;
`endif
      end
   end

   assign lights = lights_q;
   assign timer  = timer_q;
   assign phase  = phase_q;
   assign state  = state_q;
`ifdef TLC_PED_EN
   assign walk   = (state_q == ST_WALK);
`endif

endmodule
